// File: rtl/qpsk_symbol_scheduler_pkg.sv
// rtl/qpsk_symbol_scheduler_pkg.sv - shared QPSK constants and scheduler state encoding
package qpsk_symbol_scheduler_pkg;

   // One full carrier period in LUT samples; the modulator LUT uses the same length.
   localparam int QPSK_SAMPLES_PER_SYM = 100;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } qpsk_state_t;

endpackage

// File: rtl/qpsk_dibit_fifo.sv
// rtl/qpsk_dibit_fifo.sv - 2-entry, 2-bit first-word-fall-through dibit FIFO
module qpsk_dibit_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic [1:0] cnt
);

   logic [1:0] mem0;   // head entry, presented on dout
   logic [1:0] mem1;
   logic       do_push;
   logic       do_pop;

   assign dout    = mem0;
   assign do_pop  = pop && (cnt != 2'd0);
   assign do_push = push && ((cnt != 2'd2) || do_pop);

   // Storage and occupancy; a simultaneous push and pop keeps the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0 <= 2'b00;
         mem1 <= 2'b00;
         cnt  <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) mem0 <= din;
               else             mem1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               mem0 <= mem1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  mem0 <= din;
               end else begin
                  mem0 <= mem1;
                  mem1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// rtl/qpsk_symbol_scheduler.sv - pairs serial bits into dibits and paces them one carrier period each
module qpsk_symbol_scheduler
   import qpsk_symbol_scheduler_pkg::*;
#(
   parameter int SAMPLES_PER_SYM = QPSK_SAMPLES_PER_SYM,
   parameter int PHASE_W         = 7,
   parameter int CNT_W           = 16
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               enable,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   output logic               E,
   output logic               O,
   output logic [PHASE_W-1:0] phase_idx,
   output logic               mod_valid,
   output logic               sym_start,
   output logic               underrun,
   output logic [CNT_W-1:0]   sym_count
);

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SAMPLES_PER_SYM - 1);

   qpsk_state_t        state, state_nxt;
   logic               half_v, half_bit, half_v_nxt;
   logic               accept, push, pop, load;
   logic [1:0]         fifo_dout, fifo_cnt, cnt_nxt;
   logic               e_nxt, o_nxt, mod_valid_nxt, sym_start_nxt, underrun_nxt;
   logic [PHASE_W-1:0] phase_nxt;
   logic [CNT_W-1:0]   count_nxt;

   assign accept     = bit_valid && bit_ready;
   assign push       = accept && half_v;
   assign half_v_nxt = accept ? !half_v : half_v;
   assign cnt_nxt    = fifo_cnt + {1'b0, push} - {1'b0, pop};

   qpsk_dibit_fifo u_fifo (
      .clk   (Clk),
      .rst_n (Rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({half_bit, bit_in}),
      .dout  (fifo_dout),
      .cnt   (fifo_cnt)
   );

   // Half-dibit holding register and registered ready (reflects post-edge occupancy).
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         half_v    <= 1'b0;
         half_bit  <= 1'b0;
         bit_ready <= 1'b0;
      end else begin
         if (accept && !half_v) half_bit <= bit_in;
         half_v    <= half_v_nxt;
         bit_ready <= !half_v_nxt || (cnt_nxt < 2'd2);
      end
   end

   // State register and registered modulator-facing outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= ST_IDLE;
         E         <= 1'b0;
         O         <= 1'b0;
         phase_idx <= '0;
         mod_valid <= 1'b0;
         sym_start <= 1'b0;
         underrun  <= 1'b0;
         sym_count <= '0;
      end else begin
         state     <= state_nxt;
         E         <= e_nxt;
         O         <= o_nxt;
         phase_idx <= phase_nxt;
         mod_valid <= mod_valid_nxt;
         sym_start <= sym_start_nxt;
         underrun  <= underrun_nxt;
         sym_count <= count_nxt;
      end
   end

   // Next state: symbols only change on period boundaries; a running symbol always completes.
   always_comb begin
      state_nxt     = state;
      load          = 1'b0;
      pop           = 1'b0;
      e_nxt         = E;
      o_nxt         = O;
      phase_nxt     = phase_idx;
      mod_valid_nxt = mod_valid;
      sym_start_nxt = 1'b0;
      underrun_nxt  = 1'b0;
      count_nxt     = sym_count;
      case (state)
         ST_IDLE: begin
            phase_nxt     = '0;
            mod_valid_nxt = 1'b0;
            if (enable && (fifo_cnt != 2'd0)) load = 1'b1;
         end
         ST_RUN: begin
            if (phase_idx == PHASE_LAST) begin
               if (enable && (fifo_cnt != 2'd0)) begin
                  load = 1'b1;
               end else begin
                  underrun_nxt  = enable;
                  state_nxt     = ST_IDLE;
                  mod_valid_nxt = 1'b0;
                  phase_nxt     = '0;
               end
            end else begin
               phase_nxt     = phase_idx + PHASE_W'(1);
               mod_valid_nxt = 1'b1;
            end
         end
      endcase
      if (load) begin
         pop           = 1'b1;
         e_nxt         = fifo_dout[1];
         o_nxt         = fifo_dout[0];
         phase_nxt     = '0;
         mod_valid_nxt = 1'b1;
         sym_start_nxt = 1'b1;
         count_nxt     = sym_count + CNT_W'(1);
         state_nxt     = ST_RUN;
      end
   end

endmodule
